// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: controller state encoding
// and the default operand width.
package div_pkg;

    localparam int DIV_WIDTH_DEFAULT = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

endpackage : div_pkg

// File: rtl/div_step.sv
// One restoring-division iteration. The next dividend bit is shifted into
// the partial remainder, the divisor is trial-subtracted, and the sign of
// the WIDTH+1-bit difference (the borrow) decides whether to restore. The
// quotient bit is shifted into the low end of the dividend register as the
// dividend bits leave through its top.
module div_step
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic [WIDTH-1:0] quo_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic [WIDTH-1:0] quo_out
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;
    logic           borrow;

    // The incoming remainder is always below the divisor, so the shifted
    // value is below twice the divisor. The difference therefore fits in
    // WIDTH+1 signed bits, and its top bit is a reliable borrow.
    assign shifted = {rem_in, quo_in[WIDTH-1]};
    assign trial   = shifted - {1'b0, divisor};
    assign borrow  = trial[WIDTH];

    assign rem_out = borrow ? shifted[WIDTH-1:0] : trial[WIDTH-1:0];
    assign quo_out = {quo_in[WIDTH-2:0], ~borrow};

endmodule : div_step

// File: rtl/seq_divider.sv
// Multi-cycle signed/unsigned integer divider. Operand magnitudes are
// divided by a restoring shift-subtract loop, one quotient bit per cycle,
// and the result signs are applied in a final fix-up cycle. The published
// results live in their own registers so they stay stable while the next
// division is being computed.
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = $clog2(WIDTH);

    div_state_t state;
    div_state_t next_state;

    logic [CW-1:0]    count;
    logic [WIDTH-1:0] rem_work;
    logic [WIDTH-1:0] quo_work;
    logic [WIDTH-1:0] den_abs;
    logic             neg_quo;
    logic             neg_rem;

    logic [WIDTH-1:0] step_rem;
    logic [WIDTH-1:0] step_quo;
    logic [WIDTH-1:0] dividend_abs;
    logic [WIDTH-1:0] divisor_abs;
    logic             dividend_neg;
    logic             divisor_neg;
    logic             zero_den;

    // Magnitudes are only taken in signed mode; the most-negative value maps
    // onto itself, which is exactly its magnitude read as unsigned.
    assign dividend_neg = is_signed & dividend[WIDTH-1];
    assign divisor_neg  = is_signed & divisor[WIDTH-1];
    assign dividend_abs = dividend_neg ? -dividend : dividend;
    assign divisor_abs  = divisor_neg  ? -divisor  : divisor;
    assign zero_den     = (divisor == '0);

    // Status flags decode straight from the state register.
    assign busy = (state == CALC) || (state == FIX);
    assign done = (state == DONE);

    div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_work),
        .quo_in  (quo_work),
        .divisor (den_abs),
        .rem_out (step_rem),
        .quo_out (step_quo)
    );

    // Controller state register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Controller sequencing: a zero divisor skips straight to the result.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = zero_den ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == '0) begin
                    next_state = FIX;
                end
            end
            FIX:     next_state = DONE;
            DONE:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Operand capture, iteration, sign fix-up and result publication.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count       <= '0;
            rem_work    <= '0;
            quo_work    <= '0;
            den_abs     <= '0;
            neg_quo     <= 1'b0;
            neg_rem     <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        rem_work <= '0;
                        quo_work <= dividend_abs;
                        den_abs  <= divisor_abs;
                        neg_quo  <= dividend_neg ^ divisor_neg;
                        neg_rem  <= dividend_neg;
                        count    <= CW'(WIDTH - 1);
                        if (zero_den) begin
                            quotient    <= '1;
                            remainder   <= dividend;
                            div_by_zero <= 1'b1;
                        end
                    end
                end
                CALC: begin
                    rem_work <= step_rem;
                    quo_work <= step_quo;
                    if (count != '0) begin
                        count <= count - CW'(1);
                    end
                end
                FIX: begin
                    quotient    <= neg_quo ? -quo_work : quo_work;
                    remainder   <= neg_rem ? -rem_work : rem_work;
                    div_by_zero <= 1'b0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed corner cases, start/reset interference,
// and a randomized run against a plain-arithmetic reference model.
module tb_seq_divider;

    localparam int WIDTH = 32;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_by_zero;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH-1:0] last_q = '0;
    logic [WIDTH-1:0] last_r = '0;

    seq_divider #(
        .WIDTH (WIDTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard stop in case the bench itself gets stuck.
    initial begin
        #3ms;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] expected);
        checks++;
        if (got !== expected) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, expected);
        end
    endtask

    // Reference division written directly from the arithmetic definition.
    function automatic void refDiv(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] q, output logic [31:0] r, output logic dz);
        longint sa;
        longint sb;
        longint sq;
        longint sr;
        if (b == 32'd0) begin
            q  = 32'hFFFF_FFFF;
            r  = a;
            dz = 1'b1;
            return;
        end
        dz = 1'b0;
        if (sgn) begin
            sa = longint'(signed'(a));
            sb = longint'(signed'(b));
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        sq = sa / sb;
        sr = sa % sb;
        q  = sq[31:0];
        r  = sr[31:0];
    endfunction

    // Present one start pulse; returns just after the accepting edge with
    // the operand buses scrambled to prove they were latched.
    task automatic applyStimulus(input logic sgn, input logic [31:0] a, input logic [31:0] b);
        is_signed = sgn;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        tick();
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom_range(0, 1);
    endtask

    // Run one division to completion and check timing, held outputs and results.
    task automatic runOp(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_q, input logic [31:0] exp_r, input logic exp_dz);
        int n;
        applyStimulus(sgn, a, b);
        if (!exp_dz) checkOutput("busy_after_accept", busy, 1);
        n = 0;
        while (!done && n < 100) begin
            if (!exp_dz && n == 16) begin
                checkOutput("hold_quotient", quotient, last_q);
                checkOutput("hold_remainder", remainder, last_r);
            end
            tick();
            n++;
        end
        checkOutput("latency", n + 1, exp_dz ? 1 : WIDTH + 2);
        if (done) begin
            checkOutput("quotient", quotient, exp_q);
            checkOutput("remainder", remainder, exp_r);
            checkOutput("div_by_zero", div_by_zero, exp_dz);
            checkOutput("busy_in_done", busy, 0);
            tick();
            checkOutput("done_pulse_width", done, 0);
        end
        last_q = exp_q;
        last_r = exp_r;
    endtask

    initial begin
        int e;
        int done_seen;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        logic        sgn;

        // Reset with a start request present in the same cycles.
        rst_n     = 1'b0;
        start     = 1'b1;
        is_signed = 1'b0;
        dividend  = 32'd100;
        divisor   = 32'd7;
        repeat (3) tick();
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_quotient", quotient, 0);
        checkOutput("reset_remainder", remainder, 0);
        checkOutput("reset_div_by_zero", div_by_zero, 0);
        rst_n = 1'b1;
        start = 1'b0;
        tick();
        checkOutput("start_in_reset_ignored", busy, 0);

        // Directed corner cases with hand-computed results.
        runOp(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
        runOp(1'b1, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0);
        runOp(1'b1, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2, 1'b0);
        runOp(1'b0, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 32'h1234_5678, 1'b1);
        runOp(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0, 1'b0);
        runOp(1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 1'b0);
        runOp(1'b1, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14, 32'hFFFF_FFFE, 1'b0);

        // A start pulse while busy must not disturb the running division.
        applyStimulus(1'b0, 32'd100, 32'd7);
        e = 0;
        while (!done && e < 100) begin
            if (e == 9) begin
                start     = 1'b1;
                is_signed = 1'b1;
                dividend  = 32'd50;
                divisor   = 32'd5;
            end
            tick();
            e++;
            if (e == 10) start = 1'b0;
        end
        checkOutput("busy_start_latency", e + 1, WIDTH + 2);
        checkOutput("busy_start_quotient", quotient, 14);
        checkOutput("busy_start_remainder", remainder, 2);
        last_q = 32'd14;
        last_r = 32'd2;

        // A start pulse during the done cycle must be ignored too.
        start    = 1'b1;
        dividend = 32'd9;
        divisor  = 32'd3;
        tick();
        start = 1'b0;
        checkOutput("done_start_busy", busy, 0);
        checkOutput("done_start_done", done, 0);
        tick();
        checkOutput("done_start_still_idle", busy, 0);
        checkOutput("done_start_quotient_held", quotient, 14);

        // Reset in the middle of a division aborts it silently.
        applyStimulus(1'b0, 32'd1000, 32'd3);
        e = 0;
        while (e < 19) begin
            tick();
            e++;
        end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        checkOutput("abort_div_by_zero", div_by_zero, 0);
        done_seen = 0;
        repeat (40) begin
            tick();
            if (done) done_seen++;
        end
        checkOutput("abort_no_done", done_seen, 0);
        last_q = '0;
        last_r = '0;

        // Randomized back-to-back divisions against the reference model.
        for (int i = 0; i < 800; i++) begin
            sgn = 1'($urandom_range(0, 1));
            a   = $urandom;
            b   = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = $urandom_range(1, 15);
                2: b = 32'hFFFF_FFFF;
                3: a = 32'h8000_0000;
                4: b = b >> $urandom_range(0, 31);
                5: a = a >> $urandom_range(0, 31);
                default: begin
                end
            endcase
            refDiv(sgn, a, b, q, r, dz);
            runOp(sgn, a, b, q, r, dz);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_seq_divider
